lfsr_decrypt_ctrl: RTL and testbench

Phase sequencer for the Lab 5 LFSR decryption datapath. It owns the single `dat_mem` read/write port and runs five phases with explicit state rather than fixed cycle-count windows:

- seed capture
- tap-pattern detection
- 64-byte decode
- preamble scan
- message shift-down

A `start`/`done` handshake sits between this block and the top level. Results are reported as the detected tap index and the preamble length.

---
 rtl/lfsr_pkg.sv | 58 +++++
 rtl/lfsr6_step.sv | 18 +
 rtl/lfsr_decrypt_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_lfsr_decrypt_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants, state encoding and tap lookup for the
//                LFSR decryption phase sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Message geometry: plaintext lands at 0..63, ciphertext lives at 64..127
  localparam logic [6:0] MSG_LEN     = 7'd64;
  localparam logic [5:0] LAST_IDX    = 6'd63;
  localparam logic [7:0] SRC_BASE    = 8'd64;

  // Preamble and pad characters
  localparam logic [7:0] PRE_CHAR    = 8'h5F;
  localparam logic [7:0] PAD_CHAR    = 8'h20;
  // Low six bits of the preamble character; removing them from a ciphertext
  // byte of the preamble exposes the raw LFSR state
  localparam logic [5:0] PRE_LOW6    = 6'h1F;

  // Seed capture length and detection window
  localparam logic [5:0] SEED_LAST   = 6'd6;
  localparam logic [5:0] DETECT_LAST = 6'd5;
  localparam int         CHAIN_LEN   = 6;

  // Candidate feedback tap patterns, tried in index order
  localparam int         NUM_TAPS    = 6;
  localparam logic [5:0] TAP_PTRN [NUM_TAPS] =
      '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_DETECT = 3'd2,
    ST_DECODE = 3'd3,
    ST_SCAN   = 3'd4,
    ST_SHIFT  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Tap pattern for a 3-bit index; unused indices give an all-zero pattern
  function automatic logic [5:0] tap_sel(input logic [2:0] idx);
    logic [5:0] t;
    case (idx)
      3'd0:    t = TAP_PTRN[0];
      3'd1:    t = TAP_PTRN[1];
      3'd2:    t = TAP_PTRN[2];
      3'd3:    t = TAP_PTRN[3];
      3'd4:    t = TAP_PTRN[4];
      3'd5:    t = TAP_PTRN[5];
      default: t = 6'h00;
    endcase
    return t;
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr6_step.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr6_step
//  Description : One combinational step of a 6-bit Fibonacci LFSR. The state
//                shifts left by one, the MSB falls off and the parity of the
//                tapped bits enters at the LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr6_step (
  input  logic [5:0] state_i,
  input  logic [5:0] taps_i,
  output logic [5:0] next_o
);

  assign next_o = {state_i[4:0], ^(state_i & taps_i)};

endmodule : lfsr6_step
`default_nettype wire

// File: rtl/lfsr_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_decrypt_ctrl
//  Description : Phase sequencer for the LFSR decryption datapath. Owns the
//                single dat_mem port and walks through seed capture, tap
//                detection, 64-byte decode, preamble scan and shift-down,
//                reporting the detected tap index and the preamble length.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_decrypt_ctrl
  import lfsr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_out_i,
  output logic [7:0] raddr_o,
  output logic [7:0] waddr_o,
  output logic [7:0] data_in_o,
  output logic       write_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] tap_idx_o,
  output logic [6:0] km_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [5:0]       cnt_q;       // index within the current phase
  logic [6:0][5:0]  seed_q;      // s[0..6] recovered from the preamble
  logic [2:0]       tap_q;
  logic             matched_q;   // a tap has already been latched this run
  logic [5:0]       lfsr_q;
  logic [6:0]       km_q;
  logic [7:0]       raddr_q;
  logic [7:0]       waddr_q;
  logic             we_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  // Next LFSR state during decode
  logic [5:0]       lfsr_d;

  // Combinational helpers
  logic [5:0]       w_det_tap;
  logic [5:0]       w_dec_tap;
  logic [CHAIN_LEN-1:0] w_ok;
  logic             w_match;
  logic [6:0]       w_src_idx;

  // --------------------------------------------------------------------------
  // Tap detection: six chained steps from s[0] under the candidate tap. The
  // candidate matches only if every intermediate state equals the captured
  // s[1..6].
  // --------------------------------------------------------------------------
  assign w_det_tap = tap_sel(cnt_q[2:0]);

  for (genvar g = 0; g < CHAIN_LEN; g++) begin : g_detect_chain
    logic [5:0] w_in;
    logic [5:0] w_out;

    if (g == 0) begin : g_head
      assign w_in = seed_q[0];
    end else begin : g_link
      assign w_in = g_detect_chain[g-1].w_out;
    end

    lfsr6_step u_step (
      .state_i (w_in),
      .taps_i  (w_det_tap),
      .next_o  (w_out)
    );

    assign w_ok[g] = (w_out == seed_q[g+1]);
  end

  assign w_match = &w_ok;

  // --------------------------------------------------------------------------
  // Decode keystream generator
  // --------------------------------------------------------------------------
  assign w_dec_tap = tap_sel(tap_q);

  lfsr6_step u_dec_step (
    .state_i (lfsr_q),
    .taps_i  (w_dec_tap),
    .next_o  (lfsr_d)
  );

  // Source index for the shift-down copy (max 63+64, fits in 7 bits)
  assign w_src_idx = {1'b0, cnt_q} + km_q;

  // Write data depends on the read data of the same cycle, so it is formed
  // combinationally; outside the writing phases it is held at zero
  always_comb begin
    data_in_o = 8'h00;
    case (state_q)
      ST_DECODE: data_in_o = data_out_i ^ {2'b00, lfsr_q};
      ST_SHIFT:  data_in_o = (w_src_idx < MSG_LEN) ? data_out_i : PAD_CHAR;
      default:   data_in_o = 8'h00;
    endcase
  end

  // Phase sequencer; addresses and strobes are set up one cycle ahead so the
  // memory port is driven straight from registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      seed_q    <= '0;
      tap_q     <= '0;
      matched_q <= 1'b0;
      lfsr_q    <= '0;
      km_q      <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q   <= ST_SEED;
            cnt_q     <= '0;
            raddr_q   <= SRC_BASE;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tap_q     <= '0;
            km_q      <= '0;
            matched_q <= 1'b0;
          end
        end

        ST_SEED: begin
          seed_q[cnt_q[2:0]] <= data_out_i[5:0] ^ PRE_LOW6;
          if (cnt_q == SEED_LAST) begin
            state_q <= ST_DETECT;
            cnt_q   <= '0;
            raddr_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 6'd1;
            raddr_q <= SRC_BASE + {2'b00, cnt_q} + 8'd1;
          end
        end

        ST_DETECT: begin
          // First matching candidate wins; later matches are ignored
          if (w_match && !matched_q) begin
            tap_q     <= cnt_q[2:0];
            matched_q <= 1'b1;
          end
          if (cnt_q == DETECT_LAST) begin
            cnt_q <= '0;
            if (matched_q || w_match) begin
              state_q <= ST_DECODE;
              raddr_q <= SRC_BASE;
              waddr_q <= '0;
              we_q    <= 1'b1;
              lfsr_q  <= seed_q[0];
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

        ST_DECODE: begin
          lfsr_q <= lfsr_d;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 6'd1;
            raddr_q <= SRC_BASE + {2'b00, cnt_q} + 8'd1;
            waddr_q <= {2'b00, cnt_q} + 8'd1;
          end
        end

        ST_SCAN: begin
          if (data_out_i != PRE_CHAR) begin
            // First shift read is at index 0 + km = current index
            km_q    <= {1'b0, cnt_q};
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            raddr_q <= {2'b00, cnt_q};
            waddr_q <= '0;
            we_q    <= 1'b1;
          end else if (cnt_q == LAST_IDX) begin
            // Whole message is preamble: shift-down only pads
            km_q    <= MSG_LEN;
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            raddr_q <= {1'b0, MSG_LEN};
            waddr_q <= '0;
            we_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 6'd1;
            raddr_q <= {2'b00, cnt_q} + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 6'd1;
            waddr_q <= {2'b00, cnt_q} + 8'd1;
            raddr_q <= {1'b0, w_src_idx} + 8'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign raddr_o    = raddr_q;
  assign waddr_o    = waddr_q;
  assign write_en_o = we_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign tap_idx_o  = tap_q;
  assign km_o       = km_q;

endmodule : lfsr_decrypt_ctrl
`default_nettype wire

// File: tb/tb_lfsr_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_decrypt_ctrl
//  Description : Directed self-checking bench for lfsr_decrypt_ctrl with a
//                256-byte combinational-read memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_decrypt_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_out;
  logic [7:0] raddr;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       write_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] tap_idx;
  logic [6:0] km;

  logic [7:0] mem    [256];
  logic [7:0] plain  [64];
  logic [7:0] expmem [64];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       we_clr;
  int         we_cnt;

  int checks   = 0;
  int failures = 0;
  int dc;

  lfsr_decrypt_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .data_out_i (data_out),
    .raddr_o    (raddr),
    .waddr_o    (waddr),
    .data_in_o  (data_in),
    .write_en_o (write_en),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .tap_idx_o  (tap_idx),
    .km_o       (km)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on the rising edge; bench loads use the
  // same port when the DUT is not writing
  assign data_out = mem[raddr];

  always @(posedge clk) begin
    if (write_en)   mem[waddr]   <= data_in;
    else if (ld_en) mem[ld_addr] <= ld_data;
    if (we_clr)        we_cnt <= 0;
    else if (write_en) we_cnt <= we_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] step6(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    int first;
    bad   = 0;
    first = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== expmem[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    assert (bad == 0) else begin
      failures++;
      $error("FAIL %s: %0d bytes differ, first addr %0d observed=%0h expected=%0h",
             tag, bad, first, mem[first], expmem[first]);
    end
  endtask

  // Dest area prefilled with C3, plaintext encrypted into 64..127
  task automatic load_image(input logic [5:0] tap, input logic [5:0] seed, input bit corrupt);
    logic [5:0] l;
    l = seed;
    for (int a = 0; a < 128; a++) begin
      ld_en   = 1'b1;
      ld_addr = a[7:0];
      if (a < 64) begin
        ld_data = 8'hC3;
      end else begin
        ld_data = plain[a-64] ^ {2'b00, l};
        l = step6(l, tap);
        if (corrupt && a == 67) ld_data = ld_data ^ 8'h01;
      end
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  // Start a job (edge 0 samples start) and return the cycle in which done is
  // first seen; 0 means the bound expired. Optional start pulses at pa/pb.
  task automatic run_job(input int pa, input int pb, output int done_cyc);
    int cyc;
    we_clr = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    we_clr = 1'b0;
    start  = 1'b0;
    cyc    = 1;
    chk("start_busy", busy, 1);
    chk("start_clears_done", done, 0);
    chk("start_clears_err", err, 0);
    chk("start_clears_km", km, 0);
    done_cyc = 0;
    while (cyc < 400) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == pa || cyc == pb) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    we_clr  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    we_clr = 1'b0;

    // ---------------- reset state ----------------
    chk("rst_raddr", raddr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_km", km, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // ---------------- tap 2D, seed 15, 10-byte preamble ----------------
    for (int i = 0; i < 64; i++) begin
      plain[i]  = (i < 10) ? 8'h5F : 8'(65 + (i - 10) % 26);
      expmem[i] = (i < 54) ? 8'(65 + i % 26) : 8'h20;
    end
    load_image(6'h2D, 6'h15, 1'b0);
    run_job(0, 0, dc);
    chk("t1_done_cycle", dc, 153);
    chk("t1_tap_idx", tap_idx, 1);
    chk("t1_km", km, 10);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);
    chk("t1_writes", we_cnt, 128);
    check_mem("t1_mem");

    // ---------------- tap 39, seed 01, no preamble ----------------
    for (int i = 0; i < 64; i++) begin
      plain[i]  = (i < 7) ? 8'hDF : 8'(65 + i % 26);
      expmem[i] = plain[i];
    end
    load_image(6'h39, 6'h01, 1'b0);
    run_job(0, 0, dc);
    chk("t2_done_cycle", dc, 143);
    chk("t2_tap_idx", tap_idx, 5);
    chk("t2_km", km, 0);
    check_mem("t2_mem");

    // ---------------- all preamble ----------------
    for (int i = 0; i < 64; i++) begin
      plain[i]  = 8'h5F;
      expmem[i] = 8'h20;
    end
    load_image(6'h2D, 6'h15, 1'b0);
    run_job(0, 0, dc);
    chk("t3_done_cycle", dc, 206);
    chk("t3_tap_idx", tap_idx, 1);
    chk("t3_km", km, 64);
    chk("t3_writes", we_cnt, 128);
    check_mem("t3_mem");

    // ---------------- corrupted byte 67: no tap matches ----------------
    for (int i = 0; i < 64; i++) begin
      plain[i]  = (i < 10) ? 8'h5F : 8'(65 + (i - 10) % 26);
      expmem[i] = 8'hC3;
    end
    load_image(6'h2D, 6'h15, 1'b1);
    run_job(0, 0, dc);
    chk("t4_done_cycle", dc, 14);
    chk("t4_err", err, 1);
    chk("t4_tap_idx", tap_idx, 0);
    chk("t4_km", km, 0);
    chk("t4_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_done_held", done, 1);
    chk("t4_writes", we_cnt, 0);
    check_mem("t4_mem");

    // ---------------- reset mid-DECODE, then fresh run ----------------
    for (int i = 0; i < 64; i++) begin
      expmem[i] = (i < 54) ? 8'(65 + i % 26) : 8'h20;
    end
    load_image(6'h2D, 6'h15, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("t5_pre_write_en", write_en, 1);
    chk("t5_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_write_en", write_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_raddr", raddr, 0);
    chk("t5_rst_waddr", waddr, 0);
    chk("t5_rst_data_in", data_in, 0);
    chk("t5_rst_tap_idx", tap_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 0, dc);
    chk("t5_done_cycle", dc, 153);
    chk("t5_tap_idx", tap_idx, 1);
    chk("t5_km", km, 10);
    check_mem("t5_mem");

    // ---------------- start pulses while busy are ignored ----------------
    load_image(6'h2D, 6'h15, 1'b0);
    run_job(5, 100, dc);
    chk("t6_done_cycle", dc, 153);
    chk("t6_tap_idx", tap_idx, 1);
    chk("t6_km", km, 10);
    chk("t6_writes", we_cnt, 128);
    check_mem("t6_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lfsr_decrypt_ctrl
`default_nettype wire
